// File: rtl/uart_tx_sched.sv
// Two-requester UART frame scheduler: grants one byte per frame and paces the 10 bit periods.
// Latency: ack/po_flag are combinational in the grant cycle; done pulses 10*BAUD_CNT_MAX+1 cycles later.
// Backpressure: requests are ignored while a frame is in flight; the `UART_TX_SCHED_RR_EN macro selects round-robin arbitration over fixed req0 priority.
module uart_tx_sched #(
    parameter int BAUD_CNT_MAX = 5207,
    parameter int BAUD_W       = 13
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       po_flag,
    output logic [7:0] po_data,
    output logic       tx_bit_flag,
    output logic [3:0] tx_bit_cnt,
    output logic       busy,
    output logic       grant,
    output logic       done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic              baud_end;
    logic              grant_now;
    logic              win;

    assign baud_end  = (baud_cnt == BAUD_W'(BAUD_CNT_MAX - 1));
    // Gated with rst_n so the combinational pulses also drop the moment reset asserts.
    assign grant_now = rst_n && (state == IDLE) && (req0 || req1);

`ifdef UART_TX_SCHED_RR_EN
    logic rr_pri;   // 1: req1 wins the next tie

    always_comb begin
        win = ~req0;
        if (req0 && req1)
            win = rr_pri;
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n)
            rr_pri <= 1'b0;
        else if (grant_now)
            rr_pri <= ~win;
    end
`else
    always_comb win = ~req0;
`endif

    assign po_flag     = grant_now;
    assign ack0        = grant_now && !win;
    assign ack1        = grant_now && win;
    assign busy        = (state == SEND);
    assign tx_bit_flag = (state == SEND) && (baud_cnt == '0);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            tx_bit_cnt <= 4'd0;
            po_data    <= 8'h00;
            grant      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (grant_now) begin
                    state      <= SEND;
                    baud_cnt   <= '0;
                    tx_bit_cnt <= 4'd0;
                    po_data    <= win ? data1 : data0;
                    grant      <= win;
                end
            end else begin
                if (baud_end) begin
                    baud_cnt <= '0;
                    if (tx_bit_cnt == 4'd9) begin
                        state      <= IDLE;
                        tx_bit_cnt <= 4'd0;
                        done       <= 1'b1;
                    end else begin
                        tx_bit_cnt <= tx_bit_cnt + 4'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + BAUD_W'(1);
                end
            end
        end
    end

endmodule
